// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Contents: display word width, board tick divider, FSM state encoding.
package seg_disp_pkg;

    localparam int DISP_W          = 16;
    localparam int TICK_DIV_100MHZ = 100_000;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW,
        FORCE
    } state_e;

endpackage

// File: rtl/seg_display_arbiter_tick.sv
// ms_tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks.
// Ports: clk, rst_n (async, active-low) in; tick out (registered).
module ms_tick_gen
    import seg_disp_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_100MHZ
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        tick_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit 7-segment driver among N_SRC sources; source 0 is the
// background, sources 1.. take the display for HOLD_MS after an event.
// Ports: clk, rst_n, src_valid[N_SRC], src_data[16*N_SRC], force_en,
// force_sel[SW] in; disp_data[16], disp_on, owner[SW], pending[N_SRC] out.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter  int N_SRC    = 3,
    parameter  int TICK_DIV = TICK_DIV_100MHZ,
    parameter  int HOLD_MS  = 2000,
    parameter  int BLANK_MS = 50,
    localparam int SW       = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [DISP_W*N_SRC-1:0]   src_data,
    input  logic                      force_en,
    input  logic [SW-1:0]             force_sel,
    output logic [DISP_W-1:0]         disp_data,
    output logic                      disp_on,
    output logic [SW-1:0]             owner,
    output logic [N_SRC-1:0]          pending
);

    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int BW = $clog2(BLANK_MS + 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     owner_q, owner_d;
    logic              disp_on_q, disp_on_d;
    logic [DISP_W-1:0] disp_data_q, disp_data_d;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [DISP_W-1:0] shadow_q [N_SRC];
    logic [DISP_W-1:0] shadow_d [N_SRC];
    logic [HW-1:0]     hold_q, hold_d;
    logic [BW-1:0]     blank_q, blank_d;

    logic              tick;
    logic              any_pend;
    logic [SW-1:0]     next_idx;
    logic [SW-1:0]     frc_idx;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    function automatic logic [SW-1:0] lowest_set(input logic [N_SRC-1:0] v);
        lowest_set = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = SW'(i);
        end
    endfunction

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            shadow_d[i] = src_valid[i] ? src_data[DISP_W*i +: DISP_W]
                                       : shadow_q[i];
        end

        state_d     = state_q;
        owner_d     = owner_q;
        disp_on_d   = disp_on_q;
        hold_d      = hold_q;
        blank_d     = blank_q;
        disp_data_d = shadow_q[owner_q];

        any_pend = |pending_q;
        next_idx = lowest_set(pending_q);
        frc_idx  = (int'(force_sel) >= N_SRC) ? '0 : force_sel;

        if (force_en) begin
            state_d   = FORCE;
            owner_d   = frc_idx;
            disp_on_d = 1'b1;
            hold_d    = '0;
            blank_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_pend) begin
                        state_d   = BLANK;
                        owner_d   = next_idx;
                        disp_on_d = 1'b0;
                        blank_d   = '0;
                    end else begin
                        owner_d   = '0;
                        disp_on_d = 1'b1;
                    end
                end
                BLANK: begin
                    disp_on_d = 1'b0;
                    if (tick) begin
                        if (blank_q == BW'(BLANK_MS - 1)) begin
                            blank_d   = '0;
                            hold_d    = '0;
                            disp_on_d = 1'b1;
                            state_d   = (owner_q == '0) ? IDLE : SHOW;
                        end else begin
                            blank_d = blank_q + BW'(1);
                        end
                    end
                end
                SHOW: begin
                    disp_on_d = 1'b1;
                    if (any_pend && next_idx < owner_q) begin
                        // preempted event is dropped: its pending bit
                        // was already cleared on SHOW entry
                        state_d   = BLANK;
                        owner_d   = next_idx;
                        disp_on_d = 1'b0;
                        blank_d   = '0;
                        hold_d    = '0;
                    end else if (src_valid[owner_q]) begin
                        hold_d = '0;
                    end else if (tick) begin
                        if (hold_q == HW'(HOLD_MS - 1)) begin
                            state_d   = BLANK;
                            owner_d   = any_pend ? next_idx : '0;
                            disp_on_d = 1'b0;
                            blank_d   = '0;
                            hold_d    = '0;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                FORCE: begin
                    // force released: blank toward whatever IDLE would pick
                    state_d   = BLANK;
                    owner_d   = any_pend ? next_idx : '0;
                    disp_on_d = 1'b0;
                    blank_d   = '0;
                    hold_d    = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // source 0 never raises events; the shown source stays clear
        pending_d    = pending_q | src_valid;
        pending_d[0] = 1'b0;
        if (state_d == SHOW) pending_d[owner_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            disp_on_q   <= 1'b0;
            disp_data_q <= '0;
            pending_q   <= '0;
            hold_q      <= '0;
            blank_q     <= '0;
            for (int i = 0; i < N_SRC; i++) shadow_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            disp_on_q   <= disp_on_d;
            disp_data_q <= disp_data_d;
            pending_q   <= pending_d;
            hold_q      <= hold_d;
            blank_q     <= blank_d;
            for (int i = 0; i < N_SRC; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign disp_data = disp_data_q;
    assign disp_on   = disp_on_q;
    assign owner     = owner_q;
    assign pending   = pending_q;

endmodule
